// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vram_pkg
// Purpose : Shared definitions for the VRAM arbiter: FSM state encoding and
//           default address width / access length.
// Rev     : 1.0  initial release
// ============================================================================
package vram_pkg;

   localparam int unsigned ADDR_W_DEF  = 13;  // bank bit + 12-bit char address
   localparam int unsigned ACC_CYC_DEF = 2;   // clk cycles per VRAM access

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VID_RD = 2'd1,
      ST_CPU_RD = 2'd2,
      ST_CPU_WR = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : vram_arbiter_if
// Purpose : Bundles the video-fetch, CPU and VRAM-side signals of the arbiter.
//           slave  : arbiter side
//           master : requester / memory-model side
// Rev     : 1.0  initial release
// ============================================================================
interface vram_arbiter_if
   import vram_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
);
   // video fetch port
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_valid;
   logic [7:0]        vid_data;
   logic              vid_overrun;
   // CPU port
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              cpu_ack;
   logic [7:0]        cpu_rdata;
   // VRAM port
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              mem_oe_n;
   logic              mem_we_n;

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output vid_valid, vid_data, vid_overrun, cpu_ack, cpu_rdata,
             mem_addr, mem_wdata, mem_oe_n, mem_we_n
   );

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  vid_valid, vid_data, vid_overrun, cpu_ack, cpu_rdata,
             mem_addr, mem_wdata, mem_oe_n, mem_we_n
   );
endinterface
`default_nettype wire

// File: rtl/vram_wfifo.sv
`default_nettype none
// ============================================================================
// Module  : vram_wfifo
// Purpose : 2-entry CPU write FIFO holding {addr, data}.
// Ports   : clk, reset (async, active-low)
//           i_push/i_addr/i_data : enqueue (ignored when full)
//           i_pop                : drop head entry (ignored when empty)
//           o_addr/o_data        : head entry
//           o_full/o_empty       : occupancy flags
// Rev     : 1.0  initial release
// ============================================================================
module vram_wfifo
   import vram_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_data,
   input  logic              i_pop,
   output logic [ADDR_W-1:0] o_addr,
   output logic [7:0]        o_data,
   output logic              o_full,
   output logic              o_empty
);
   logic [ADDR_W-1:0] r_addr [2];
   logic [7:0]        r_data [2];
   logic              r_wp;
   logic              r_rp;
   logic [1:0]        r_cnt;

   logic w_do_push;
   logic w_do_pop;

   assign o_full    = (r_cnt == 2'd2);
   assign o_empty   = (r_cnt == 2'd0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_addr    = r_addr[r_rp];
   assign o_data    = r_data[r_rp];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_addr[r_wp] <= i_addr;
            r_data[r_wp] <= i_data;
            r_wp         <= ~r_wp;
         end
         if (w_do_pop) r_rp <= ~r_rp;
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vram_arbiter
// Purpose : Shares one VRAM between video character fetches and CPU accesses.
//           Fixed priority in IDLE: video > queued write > CPU read. Every
//           access lasts ACC_CYC cycles and is never aborted.
// Ports   : clk   - pixel clock, rising edge
//           reset - asynchronous, active-low
//           bus   - vram_arbiter_if.slave (video, CPU and VRAM signals)
// Rev     : 1.0  initial release
// ============================================================================
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned ACC_CYC = ACC_CYC_DEF
) (
   input  logic          clk,
   input  logic          reset,
   vram_arbiter_if.slave bus
);
   localparam logic [1:0] c_last_cyc = 2'(ACC_CYC - 1);
   // mem_we_n is registered, so it is pulled low at the end of this cycle
   // to be low exactly during the last access cycle
   localparam logic [1:0] c_we_cyc   = 2'(ACC_CYC - 2);

   state_t            r_state;
   logic [1:0]        r_cyc;
   logic              r_vid_pend;
   logic [ADDR_W-1:0] r_vid_addr;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_wdata;
   logic              r_oe_n;
   logic              r_we_n;
   logic              r_cpu_ack;
   logic [7:0]        r_cpu_rdata;
   logic              r_vid_valid;
   logic [7:0]        r_vid_data;
   logic              r_overrun;

   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [ADDR_W-1:0] w_fifo_addr;
   logic [7:0]        w_fifo_data;
   logic              w_push;
   logic              w_pop;
   logic              w_rd_req;
   logic              w_vid_any;
   logic [ADDR_W-1:0] w_vid_addr;
   logic              w_last;

   // cpu_req is not re-sampled while cpu_ack is high, so a held request
   // is accepted only once
   assign w_push     = bus.cpu_req & bus.cpu_we & ~r_cpu_ack & ~w_fifo_full;
   assign w_rd_req   = bus.cpu_req & ~bus.cpu_we & ~r_cpu_ack;
   // a strobe arriving in IDLE is served directly; the newest address wins
   assign w_vid_any  = r_vid_pend | bus.vid_req;
   assign w_vid_addr = bus.vid_req ? bus.vid_addr : r_vid_addr;
   assign w_last     = (r_cyc == c_last_cyc);
   // the write entry leaves the FIFO only once its access has completed
   assign w_pop      = (r_state == ST_CPU_WR) & w_last;

   vram_wfifo #(.ADDR_W(ADDR_W)) u_wfifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_addr  (bus.cpu_addr),
      .i_data  (bus.cpu_wdata),
      .i_pop   (w_pop),
      .o_addr  (w_fifo_addr),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cyc       <= 2'd0;
         r_vid_pend  <= 1'b0;
         r_vid_addr  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 8'h00;
         r_oe_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_cpu_ack   <= 1'b0;
         r_cpu_rdata <= 8'h00;
         r_vid_valid <= 1'b0;
         r_vid_data  <= 8'h00;
         r_overrun   <= 1'b0;
      end else begin
         r_cpu_ack   <= w_push;
         r_vid_valid <= 1'b0;
         // a second strobe before the first was started loses the first
         if (bus.vid_req && r_vid_pend) r_overrun <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               r_cyc <= 2'd0;
               if (w_vid_any) begin
                  r_state    <= ST_VID_RD;
                  r_mem_addr <= w_vid_addr;
                  r_oe_n     <= 1'b0;
                  r_vid_pend <= 1'b0;
               end else if (!w_fifo_empty) begin
                  r_state     <= ST_CPU_WR;
                  r_mem_addr  <= w_fifo_addr;
                  r_mem_wdata <= w_fifo_data;
               end else if (w_rd_req) begin
                  r_state    <= ST_CPU_RD;
                  r_mem_addr <= bus.cpu_addr;
                  r_oe_n     <= 1'b0;
               end
            end
            default: begin
               if (bus.vid_req) begin
                  r_vid_pend <= 1'b1;
                  r_vid_addr <= bus.vid_addr;
               end
               if (w_last) begin
                  r_state <= ST_IDLE;
                  r_cyc   <= 2'd0;
                  r_oe_n  <= 1'b1;
                  r_we_n  <= 1'b1;
                  if (r_state == ST_VID_RD) begin
                     r_vid_valid <= 1'b1;
                     r_vid_data  <= bus.mem_rdata;
                  end
                  if (r_state == ST_CPU_RD) begin
                     r_cpu_ack   <= 1'b1;
                     r_cpu_rdata <= bus.mem_rdata;
                  end
               end else begin
                  r_cyc <= r_cyc + 2'd1;
                  if ((r_state == ST_CPU_WR) && (r_cyc == c_we_cyc)) r_we_n <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_wdata   = r_mem_wdata;
   assign bus.mem_oe_n    = r_oe_n;
   assign bus.mem_we_n    = r_we_n;
   assign bus.cpu_ack     = r_cpu_ack;
   assign bus.cpu_rdata   = r_cpu_rdata;
   assign bus.vid_valid   = r_vid_valid;
   assign bus.vid_data    = r_vid_data;
   assign bus.vid_overrun = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_arbiter
// Purpose : Self-checking bench for vram_arbiter (ADDR_W=13, ACC_CYC=2).
//           Stimulus pushes expected responses into queues; a monitor on the
//           falling edge pops and compares on vid_valid, cpu_ack and each
//           mem_we_n pulse. A byte-array VRAM model answers reads.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;
   typedef struct packed {
      logic       is_rd;
      logic [7:0] data;
   } ack_t;

   logic clk;
   logic reset;

   vram_arbiter_if #(.ADDR_W(13)) bus ();

   vram_arbiter #(.ADDR_W(13), .ACC_CYC(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0]  mem [0:8191];
   logic [7:0]  vid_q [$];
   ack_t        ack_q [$];
   logic [20:0] wr_q  [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_we     = 0;
   int          n_ack    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // VRAM model: asynchronous read, write on the rising edge while we_n is low
   assign bus.mem_rdata = mem[bus.mem_addr];
   always @(posedge clk) if (!bus.mem_we_n) mem[bus.mem_addr] <= bus.mem_wdata;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic check_ok(input string name, input bit ok, input int act, input string req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, required %s", name, act, req);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : mon
      logic [7:0]  e_v;
      ack_t        e_a;
      logic [20:0] e_w;
      if (reset) begin
         if (!bus.mem_oe_n && !bus.mem_we_n)
            check_ok("oe_we_overlap", 1'b0, 1, "never both low");
         if (bus.vid_valid) begin
            if (vid_q.size() == 0) check_ok("vid_unexpected", 1'b0, 32'(bus.vid_data), "no vid_valid");
            else begin
               e_v = vid_q.pop_front();
               check_eq("vid_data", 32'(bus.vid_data), 32'(e_v));
            end
         end
         if (bus.cpu_ack) begin
            n_ack++;
            if (ack_q.size() == 0) check_ok("ack_unexpected", 1'b0, 1, "no cpu_ack");
            else begin
               e_a = ack_q.pop_front();
               if (e_a.is_rd) check_eq("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_a.data));
            end
         end
         if (!bus.mem_we_n) begin
            n_we++;
            if (wr_q.size() == 0) check_ok("we_unexpected", 1'b0, 32'(bus.mem_addr), "no write");
            else begin
               e_w = wr_q.pop_front();
               check_eq("mem_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(e_w));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [12:0] a, input logic [7:0] d, output int lat);
      ack_q.push_back('{is_rd: 1'b0, data: 8'h00});
      wr_q.push_back({a, d});
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!bus.cpu_ack && lat < 30);
      if (!bus.cpu_ack) check_ok("cpu_write_timeout", 1'b0, lat, "cpu_ack within 30");
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
   endtask

   task automatic cpu_read(input logic [12:0] a, input logic [7:0] exp);
      int lat;
      ack_q.push_back('{is_rd: 1'b1, data: exp});
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!bus.cpu_ack && lat < 30);
      if (!bus.cpu_ack) check_ok("cpu_read_timeout", 1'b0, lat, "cpu_ack within 30");
      bus.cpu_req = 1'b0;
   endtask

   task automatic vid_fetch(input logic [12:0] a, input logic [7:0] exp, output int lat, output int oe_cnt);
      vid_q.push_back(exp);
      bus.vid_req = 1'b1; bus.vid_addr = a;
      lat = 0; oe_cnt = 0;
      do begin
         @(posedge clk); #1;
         bus.vid_req = 1'b0;
         lat++;
         if (!bus.mem_oe_n) oe_cnt++;
      end while (!bus.vid_valid && lat < 30);
      if (!bus.vid_valid) check_ok("vid_timeout", 1'b0, lat, "vid_valid within 30");
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_oe_n"},    32'(bus.mem_oe_n),    32'd1);
      check_eq({tag, "_we_n"},    32'(bus.mem_we_n),    32'd1);
      check_eq({tag, "_addr"},    32'(bus.mem_addr),    32'd0);
      check_eq({tag, "_wdata"},   32'(bus.mem_wdata),   32'd0);
      check_eq({tag, "_ack"},     32'(bus.cpu_ack),     32'd0);
      check_eq({tag, "_rdata"},   32'(bus.cpu_rdata),   32'd0);
      check_eq({tag, "_vvalid"},  32'(bus.vid_valid),   32'd0);
      check_eq({tag, "_vdata"},   32'(bus.vid_data),    32'd0);
      check_eq({tag, "_overrun"}, 32'(bus.vid_overrun), 32'd0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- directed scenarios ----------------
   initial begin : stim
      int lat, oe_cnt, we0, ack0;
      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
      mem[13'h0123] = 8'h41;
      mem[13'h0020] = 8'h3E;
      mem[13'h0040] = 8'h66;
      mem[13'h0041] = 8'h77;
      mem[13'h0300] = 8'h11;
      mem[13'h0301] = 8'h9C;
      bus.vid_req = 1'b0; bus.vid_addr = '0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      reset = 1'b0;
      idle(3);
      check_reset_vals("rst_init");
      @(negedge clk) reset = 1'b1;
      idle(2);

      // video fetch from idle: 2 cycles of oe_n, vid_valid 3 cycles later
      vid_fetch(13'h0123, 8'h41, lat, oe_cnt);
      check_eq("vid_latency", 32'(lat), 32'd3);
      check_eq("vid_oe_cycles", 32'(oe_cnt), 32'd2);
      idle(3);

      // write then read-back at top address
      we0 = n_we;
      cpu_write(13'h1FFF, 8'h5A, lat);
      check_eq("wr_ack_latency", 32'(lat), 32'd1);
      cpu_read(13'h1FFF, 8'h5A);
      check_eq("wr_we_pulses", 32'(n_we - we0), 32'd1);
      idle(3);

      // three back-to-back writes with video idle
      we0 = n_we;
      cpu_write(13'h0010, 8'hA1, lat);
      check_eq("b2b_w1_latency", 32'(lat), 32'd1);
      cpu_write(13'h0011, 8'hB2, lat);
      cpu_write(13'h1000, 8'hC3, lat);
      check_ok("b2b_w3_after_w1_drain", (n_we - we0) >= 1, n_we - we0, ">= 1 write drained");
      idle(10);

      // video + write in the same cycle; video holds the bus so the FIFO fills
      bus.vid_req = 1'b1; bus.vid_addr = 13'h0020;
      vid_q.push_back(8'h3E);
      fork
         begin @(posedge clk); #1; bus.vid_req = 1'b0; end
      join_none
      cpu_write(13'h0030, 8'hD4, lat);
      check_eq("same_cycle_w1_latency", 32'(lat), 32'd1);
      cpu_write(13'h0031, 8'hE5, lat);
      cpu_write(13'h0032, 8'hF6, lat);
      check_ok("full_fifo_w3_withheld", (lat > 2) && (lat <= 4), lat, "3..4 cycles");
      // read must wait for both queued writes (read-after-write order)
      cpu_read(13'h0032, 8'hF6);
      idle(4);

      // video request one cycle after CPU_RD starts
      fork
         cpu_read(13'h0040, 8'h66);
         begin
            int vl, vo;
            repeat (2) @(posedge clk);
            #1;
            vid_fetch(13'h0041, 8'h77, vl, vo);
            check_ok("vid_after_rd_latency", vl <= 6, vl, "<= 6");
         end
      join
      idle(4);
      check_eq("overrun_still_clear", 32'(bus.vid_overrun), 32'd0);

      // two video strobes during CPU_WR: only the second address is fetched
      vid_q.push_back(8'h9C);
      fork
         cpu_write(13'h0200, 8'h77, lat);
         begin
            repeat (2) @(posedge clk);
            #1; bus.vid_req = 1'b1; bus.vid_addr = 13'h0300;
            @(posedge clk);
            #1; bus.vid_addr = 13'h0301;
            @(posedge clk);
            #1; bus.vid_req = 1'b0;
         end
      join
      idle(10);
      check_eq("overrun_set", 32'(bus.vid_overrun), 32'd1);

      // reset asserted in the middle of a CPU read
      ack0 = n_ack;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0123;
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      #1 check_reset_vals("rst_mid_rd");
      bus.cpu_req = 1'b0;
      @(negedge clk) reset = 1'b1;
      idle(8);
      check_eq("no_ack_after_reset", 32'(n_ack - ack0), 32'd0);
      check_eq("idle_after_reset_oe_n", 32'(bus.mem_oe_n), 32'd1);

      check_eq("vid_q_empty", 32'(vid_q.size()), 32'd0);
      check_eq("ack_q_empty", 32'(ack_q.size()), 32'd0);
      check_eq("wr_q_empty",  32'(wr_q.size()),  32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning VRAM address width (bank bit + 12-bit character address).
REQ-002 SHALL have parameter ACC_CYC, default 2, meaning clk cycles per VRAM access (2..4).
REQ-003 SHALL have port clk  input  1  single clock, the pixel clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port vid_req  input  1  one-cycle strobe requesting one video character fetch.
REQ-006 SHALL have port vid_addr  input  ADDR_W  video fetch address, sampled with vid_req.
REQ-007 SHALL have port vid_valid  output  1  one-cycle strobe, vid_data valid.
REQ-008 SHALL have port vid_data  output  8  fetched character byte, held until the next vid_valid.
REQ-009 SHALL have port cpu_req  input  1  CPU access request, held high until cpu_ack.
REQ-010 SHALL have port cpu_we  input  1  1 = write, 0 = read; qualified by cpu_req.
REQ-011 SHALL have port cpu_addr  input  ADDR_W  CPU address.
REQ-012 SHALL have port cpu_wdata  input  8  CPU write data.
REQ-013 SHALL have port cpu_ack  output  1  one-cycle acknowledge closing a CPU request.
REQ-014 SHALL have port cpu_rdata  output  8  read data, valid with cpu_ack on reads, held afterwards.
REQ-015 SHALL have port mem_addr  output  ADDR_W  VRAM address.
REQ-016 SHALL have port mem_wdata  output  8  VRAM write data.
REQ-017 SHALL have port mem_rdata  input  8  VRAM read data, sampled on the last cycle of a read access.
REQ-018 SHALL have port mem_oe_n  output  1  active-low VRAM output enable.
REQ-019 SHALL have port mem_we_n  output  1  active-low VRAM write enable.
REQ-020 SHALL have port vid_overrun  output  1  sticky flag, set when a video fetch is lost.

Function
REQ-021 SHALL implement FSM states IDLE, VID_RD, CPU_RD and CPU_WR; each access state lasts exactly ACC_CYC cycles, then returns to IDLE.
REQ-022 SHALL select in IDLE with fixed priority: pending video > non-empty write FIFO > pending CPU read; it SHALL enter the selected state on the next edge.
REQ-023 SHALL never abort an access in progress; a vid_req arriving mid-access is latched as pending.
REQ-024 SHALL assert vid_valid no later than 2*ACC_CYC+2 cycles after vid_req.
REQ-025 SHALL, on vid_req while a video fetch is already pending and not yet started, replace the pending address with the new one and set vid_overrun; vid_overrun clears only on reset.
REQ-026 SHALL accept a CPU write into a 2-entry write FIFO and pulse cpu_ack on the cycle after cpu_req is sampled, provided the FIFO is not full; when the FIFO is full, cpu_ack SHALL be withheld until an entry drains.
REQ-027 SHALL not start a CPU read until the write FIFO is empty, preserving read-after-write order.
REQ-028 SHALL pulse cpu_ack for a read one cycle after CPU_RD completes, with cpu_rdata = mem_rdata sampled on the last CPU_RD cycle.
REQ-029 SHALL hold mem_addr stable for the whole access; mem_oe_n = 0 for all VID_RD/CPU_RD cycles; mem_we_n = 0 only on the last CPU_WR cycle; both = 1 in IDLE.
REQ-030 SHALL never drive mem_oe_n and mem_we_n low in the same cycle.
REQ-031 SHALL pulse cpu_ack at most once per request, and SHALL not re-sample cpu_req in the cycle cpu_ack is high.
REQ-032 SHALL, when vid_req and a CPU write arrive in the same cycle, accept both: the video fetch is latched pending and the write is queued.

Reset
REQ-033 SHALL, while reset = 0, asynchronously force state IDLE, FIFO empty, pending flags 0, mem_oe_n = 1, mem_we_n = 1, mem_addr = 0, mem_wdata = 0, cpu_ack = 0, cpu_rdata = 0, vid_valid = 0, vid_data = 0 and vid_overrun = 0.
REQ-034 SHALL discard any access in progress when reset is asserted mid-operation, with no cpu_ack or vid_valid issued for it.

Structure
REQ-035 SHALL take the FSM state encoding, ADDR_W default and ACC_CYC default from shared package vram_pkg.
REQ-036 SHALL implement the write FIFO as sub-module vram_wfifo (2 entries of {addr, data}, with full and empty outputs).

Verification
REQ-037 SHALL cover: vid_req with addr 0x0123 in idle, memory returning 0x41 -> mem_oe_n low for 2 cycles, vid_valid 3 cycles after vid_req, vid_data = 0x41.
REQ-038 SHALL cover: CPU write 0x1FFF <- 0x5A, then CPU read 0x1FFF -> cpu_ack after 1 cycle for the write, one mem_we_n pulse, read returns 0x5A.
REQ-039 SHALL cover: three back-to-back CPU writes with video idle -> 3rd cpu_ack delayed until the first write drains; all three appear on the memory bus in order.
REQ-040 SHALL cover: vid_req one cycle after CPU_RD starts -> the read completes, VID_RD follows immediately, vid_valid within 6 cycles.
REQ-041 SHALL cover: two vid_req 1 cycle apart while CPU_WR is active -> only the second address is fetched and vid_overrun = 1.
REQ-042 SHALL cover: reset asserted during CPU_RD -> all outputs at reset values immediately, and no cpu_ack after release.
